// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the fetch PC, captures the
// combinationally returned instruction word into a small FIFO and presents
// the FIFO head to decode over a valid/ready handshake. A redirect flushes
// the FIFO and restarts fetch, and fetch halts at the end of instruction memory.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   imem_pc           - fetch address to instruction memory (the fetch PC)
//   imem_inst         - instruction word for imem_pc (combinational return)
//   redirect_valid/pc - flush and restart fetch at the word-aligned redirect_pc
//   inst_valid/ready  - decode handshake on the FIFO head
//   inst_out/inst_pc  - FIFO head instruction and its PC (zero when empty)
//   halted            - fetch stopped and FIFO drained
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 32,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        halted
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic               valid_q, valid_d;
    logic [31:0]        out_q, out_d;
    logic [31:0]        pc_q, pc_d;
    logic               halted_q, halted_d;

    logic               push;
    logic               pop;
    logic [31:0]        fetch_pc_inc;
    logic [31:0]        redirect_aligned;
    entry_t             head;

    // Next-state: FIFO bookkeeping, fetch PC, RUN/HALT and registered head outputs
    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        count_d          = count_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        mem_d            = mem_q;
        pop              = valid_q & inst_ready;
        push             = (state_q == RUN) & ((count_q < CNT_W'(DEPTH)) | pop) & ~redirect_valid;
        fetch_pc_inc     = fetch_pc_q + 32'd4;
        redirect_aligned = redirect_pc & ~32'h0000_0003;

        if (redirect_valid) begin
            // Flush wins over any pop/push this cycle
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_aligned;
            state_d    = (redirect_aligned < MEM_LIMIT) ? RUN : HALT;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: fetch_pc_q, inst: imem_inst};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                fetch_pc_d      = fetch_pc_inc;
                if (fetch_pc_inc >= MEM_LIMIT) begin
                    state_d = HALT;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Head outputs are precomputed from next state so they leave a flop
        head     = mem_d[rd_ptr_d];
        valid_d  = (count_d != '0);
        out_d    = valid_d ? head.inst : 32'h0;
        pc_d     = valid_d ? head.pc : 32'h0;
        halted_d = (state_d == HALT) && (count_d == '0);
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            valid_q    <= 1'b0;
            out_q      <= 32'h0;
            pc_q       <= 32'h0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
            pc_q       <= pc_d;
            halted_q   <= halted_d;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

    assign imem_pc    = fetch_pc_q;
    assign inst_valid = valid_q;
    assign inst_out   = out_q;
    assign inst_pc    = pc_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: instruction ROM model, a per-cycle vector table
// for the reset/backpressure stream, and a program-order scoreboard for the
// streaming, redirect and reset corner cases.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        halted;

    int errors   = 0;
    int checks   = 0;
    int accepted = 0;

    logic [31:0] rom [8] = '{32'h0094_0333, 32'h4139_03b3, 32'h035a_02b3, 32'h00b5_0533,
                             32'h019c_1eb3, 32'h40c5_8633, 32'h02d7_06b3, 32'h00f7_68b3};

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb_q [$];

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_imem;
        logic        exp_halted;
    } vec_t;
    vec_t vecs [13];

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(32),
        .DEPTH    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_pc       (imem_pc),
        .imem_inst     (imem_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    assign imem_inst = (imem_pc < 32'd32) ? rom[imem_pc[4:2]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    // Expected accepted stream from a fetch start address up to the end of memory
    task automatic fill(input logic [31:0] start);
        sb_q.delete();
        for (int a = int'(start); a < 32; a += 4) begin
            sb_q.push_back('{pc: 32'(a), inst: rom[a / 4]});
        end
    endtask

    // Called at a negedge: drive inputs, score any handshake, advance to next negedge
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rst);
        exp_t e;
        reset          = rst;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (!rst && !rv && rdy && inst_valid) begin
            accepted++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got pc=0x%08h with no entry expected", inst_pc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", inst_pc, e.pc);
                chk("sb_inst", inst_out, e.inst);
            end
        end
        if (rst) fill(32'h0);
        else if (rv) fill(rpc & ~32'h3);
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    // Stream until halted (bounded); ready toggles 1,0,1,0 when tog is set
    task automatic run_to_halt(input logic tog, input int exp_count);
        accepted = 0;
        for (int i = 0; i < 60; i++) begin
            if (halted) break;
            step(tog ? ((i % 2) == 0) : 1'b1, 1'b0, 32'h0, 1'b0);
        end
        chk("halt_timeout", 32'(halted), 32'd1);
        chk("accept_cnt", 32'(accepted), 32'(exp_count));
        chk("sb_left", 32'(sb_q.size()), 32'd0);
        chk("halt_valid", 32'(inst_valid), 32'd0);
    endtask

    initial begin
        // Backpressure for 5 cycles after reset, then free-running drain
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 32'h04, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h00, 32'h08, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h00, 32'h08, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h00, 32'h08, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h00, 32'h08, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h04, 32'h0C, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h08, 32'h10, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0C, 32'h14, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h10, 32'h18, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h14, 32'h1C, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h18, 32'h20, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'h1C, 32'h20, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h00, 32'h20, 1'b1};

        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);

        // Reset state
        do_reset();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst_out, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_imem_pc", imem_pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Table-driven backpressure and drain
        accepted = 0;
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].ready, 1'b0, 32'h0, 1'b0);
            chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_pc", i), inst_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_inst", i), inst_out,
                vecs[i].exp_valid ? rom[vecs[i].exp_pc[4:2]] : 32'h0);
            chk($sformatf("vec%0d_imem", i), imem_pc, vecs[i].exp_imem);
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
        end
        chk("vec_accept_cnt", 32'(accepted), 32'd8);
        chk("vec_sb_left", 32'(sb_q.size()), 32'd0);

        // Full-rate stream from reset
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("lat_valid", 32'(inst_valid), 32'd1);
        chk("lat_pc", inst_pc, 32'h0);
        chk("lat_inst", inst_out, 32'h0094_0333);
        run_to_halt(1'b0, 8);

        // Ready toggling 1,0,1,0
        do_reset();
        run_to_halt(1'b1, 8);

        // Redirect to unaligned 0x13 while FIFO holds 2 entries
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rd_full_valid", 32'(inst_valid), 32'd1);
        step(1'b1, 1'b1, 32'h13, 1'b0);
        chk("rd_flush_valid", 32'(inst_valid), 32'd0);
        chk("rd_imem_pc", imem_pc, 32'h10);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rd_first_pc", inst_pc, 32'h10);
        chk("rd_first_inst", inst_out, 32'h019c_1eb3);
        run_to_halt(1'b0, 4);

        // Redirect out of HALT back into memory
        chk("hr_halted_pre", 32'(halted), 32'd1);
        step(1'b1, 1'b1, 32'h04, 1'b0);
        chk("hr_halted", 32'(halted), 32'd0);
        chk("hr_valid", 32'(inst_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("hr_pc", inst_pc, 32'h04);
        chk("hr_inst", inst_out, 32'h4139_03b3);
        run_to_halt(1'b0, 7);

        // Redirect beyond memory goes straight to HALT with no push
        step(1'b1, 1'b1, 32'h40, 1'b0);
        chk("ro_halted", 32'(halted), 32'd1);
        chk("ro_valid", 32'(inst_valid), 32'd0);
        chk("ro_imem_pc", imem_pc, 32'h40);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("ro_valid2", 32'(inst_valid), 32'd0);
        chk("ro_halted2", 32'(halted), 32'd1);

        // One-cycle reset mid-stream with FIFO full
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("mr_full_imem", imem_pc, 32'h08);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mr_valid", 32'(inst_valid), 32'd0);
        chk("mr_imem_pc", imem_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("mr_first_pc", inst_pc, 32'h0);
        chk("mr_first_inst", inst_out, 32'h0094_0333);
        run_to_halt(1'b0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
